// File: rtl/dinorun_pkg.sv
// Shared types and constants for the obstacle scheduler.
//   sched_state_t : scheduler FSM state encoding (IDLE, WAIT, ARM, FROZEN)
//   SLOT_*        : bit index of each obstacle slot in busy/spawn vectors
//   MAX_LEVEL     : highest speed level reached by the scheduler
package dinorun_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ARM    = 2'd2,
      FROZEN = 2'd3
   } sched_state_t;

   localparam int SLOT_CACTUS1 = 0;
   localparam int SLOT_CACTUS2 = 1;
   localparam int SLOT_BIRD    = 2;
   localparam int MAX_LEVEL    = 2;

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector over the three obstacle slots.
// Ports:
//   eligible_i [2:0] : slots that may be spawned into this cycle
//   rr_i       [1:0] : slot to try first (0..2; 3 is treated as 0)
//   valid_o          : at least one slot is eligible
//   slot_o     [1:0] : first eligible slot in order rr, rr+1, rr+2 (mod 3)
module rr_picker (
   input  logic [2:0] eligible_i,
   input  logic [1:0] rr_i,
   output logic       valid_o,
   output logic [1:0] slot_o
);

   logic [1:0] start;

   assign start = (rr_i == 2'd3) ? 2'd0 : rr_i;

   function automatic logic [1:0] wrap3(input logic [1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= 3) sum = sum - 3;
      return 2'(sum);
   endfunction

   // Walk from the farthest candidate back to rr so the closest eligible
   // slot is the last one written.
   always_comb begin
      valid_o = 1'b0;
      slot_o  = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (eligible_i[wrap3(start, k)]) begin
            valid_o = 1'b1;
            slot_o  = wrap3(start, k);
         end
      end
   end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: paces obstacle movement per speed level, waits a
// randomised gap between spawns, and spawns into free slots round-robin.
// Ports:
//   clk_i           : clock, rising edge
//   rst_ni          : synchronous active-low reset
//   next_frame_i    : one-cycle pulse per video frame
//   run_i           : game running
//   freeze_i        : collision freeze
//   clear_i         : restart pulse
//   busy_i    [2:0] : slot occupied (0,1 cacti, 2 bird)
//   rand_i   [15:0] : LFSR value, bits [4:0] extend the spawn gap
//   spawn_o   [2:0] : one-cycle spawn pulse per slot (registered)
//   step_o          : obstacle-advance pulse, same cycle as next_frame_i
//   level_o   [1:0] : current speed level 0..2
// Build option: define OBSTACLE_SCHED_BIRD_EN to enable the bird slot;
// otherwise only the two cactus slots are used and spawn_o[2] stays 0.
//
// state  | meaning
// IDLE   | game not running, counters held
// WAIT   | counting down the gap between spawns on each step
// ARM    | gap expired, waiting for a free slot to spawn into
// FROZEN | collision freeze, everything held until clear or run drop
module obstacle_scheduler
   import dinorun_pkg::*;
#(
   parameter int MIN_GAP          = 40,
   parameter int SPAWNS_PER_LEVEL = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        next_frame_i,
   input  logic        run_i,
   input  logic        freeze_i,
   input  logic        clear_i,
   input  logic [2:0]  busy_i,
   input  logic [15:0] rand_i,
   output logic [2:0]  spawn_o,
   output logic        step_o,
   output logic [1:0]  level_o
);

`ifdef OBSTACLE_SCHED_BIRD_EN
   localparam logic [2:0] SLOT_MASK = 3'b111;
   localparam logic [1:0] RR_LAST   = 2'(SLOT_BIRD);
`else
   localparam logic [2:0] SLOT_MASK = 3'b011;
   localparam logic [1:0] RR_LAST   = 2'(SLOT_CACTUS2);
`endif

   localparam logic [7:0] MIN_GAP_W = 8'(MIN_GAP);
   localparam logic [7:0] SPL_LAST  = 8'(SPAWNS_PER_LEVEL - 1);
   localparam logic [1:0] LEVEL_MAX = 2'(MAX_LEVEL);

   sched_state_t state_q, state_d;
   logic [7:0]   gap_cnt_q, gap_cnt_d;
   logic [1:0]   frame_cnt_q, frame_cnt_d;
   logic [7:0]   spawn_cnt_q, spawn_cnt_d;
   logic [1:0]   level_q, level_d;
   logic [1:0]   rr_q, rr_d;
   logic [2:0]   spawn_q, spawn_d;

   logic [2:0]   eligible;
   logic         pick_valid;
   logic [1:0]   pick_slot;
   logic         active;
   logic         step;
   logic [7:0]   gap_reload;
   logic         unused_rand;

   assign unused_rand = ^rand_i[15:5];
   assign eligible    = ~busy_i & SLOT_MASK;
   assign gap_reload  = MIN_GAP_W + {3'b000, rand_i[4:0]};
   assign active      = (state_q == WAIT) || (state_q == ARM);

   // Level n lets 2+n of every 4 frames through; clear, freeze and a run
   // drop all suppress the step in the cycle they arrive.
   assign step = rst_ni && next_frame_i && active && run_i && !freeze_i && !clear_i &&
                 ({1'b0, frame_cnt_q} < (3'd2 + {1'b0, level_q}));

   rr_picker u_picker (
      .eligible_i (eligible),
      .rr_i       (rr_q),
      .valid_o    (pick_valid),
      .slot_o     (pick_slot)
   );

   always_comb begin
      state_d     = state_q;
      gap_cnt_d   = gap_cnt_q;
      frame_cnt_d = frame_cnt_q;
      spawn_cnt_d = spawn_cnt_q;
      level_d     = level_q;
      rr_d        = rr_q;
      spawn_d     = 3'b000;

      if (clear_i) begin
         state_d     = IDLE;
         gap_cnt_d   = 8'd0;
         frame_cnt_d = 2'd0;
         spawn_cnt_d = 8'd0;
         level_d     = 2'd0;
         rr_d        = 2'd0;
      end else if (freeze_i) begin
         if (state_q != IDLE) state_d = FROZEN;
      end else if (!run_i) begin
         state_d = IDLE;
      end else begin
         if (next_frame_i && active) frame_cnt_d = frame_cnt_q + 2'd1;
         case (state_q)
            IDLE: begin
               state_d   = WAIT;
               gap_cnt_d = gap_reload;
            end
            WAIT: begin
               if (gap_cnt_q == 8'd0) state_d = ARM;
               else if (step) gap_cnt_d = gap_cnt_q - 8'd1;
            end
            ARM: begin
               if (pick_valid) begin
                  spawn_d   = 3'b001 << pick_slot;
                  rr_d      = (pick_slot == RR_LAST) ? 2'd0 : pick_slot + 2'd1;
                  gap_cnt_d = gap_reload;
                  state_d   = WAIT;
                  if (spawn_cnt_q == SPL_LAST) begin
                     spawn_cnt_d = 8'd0;
                     if (level_q < LEVEL_MAX) level_d = level_q + 2'd1;
                  end else begin
                     spawn_cnt_d = spawn_cnt_q + 8'd1;
                  end
               end
            end
            FROZEN: begin
               state_d = FROZEN;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         gap_cnt_q   <= 8'd0;
         frame_cnt_q <= 2'd0;
         spawn_cnt_q <= 8'd0;
         level_q     <= 2'd0;
         rr_q        <= 2'd0;
         spawn_q     <= 3'b000;
      end else begin
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         spawn_cnt_q <= spawn_cnt_d;
         level_q     <= level_d;
         rr_q        <= rr_d;
         spawn_q     <= spawn_d;
      end
   end

   assign spawn_o = spawn_q & SLOT_MASK;
   assign step_o  = step;
   assign level_o = level_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler (MIN_GAP=40, SPAWNS_PER_LEVEL=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_obstacle_scheduler;
   import dinorun_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        next_frame_i;
   logic        run_i;
   logic        freeze_i;
   logic        clear_i;
   logic [2:0]  busy_i;
   logic [15:0] rand_i;
   logic [2:0]  spawn_o;
   logic        step_o;
   logic [1:0]  level_o;

   int total = 0;
   int bad   = 0;
   int n_step  = 0;
   int n_spawn = 0;
   logic [2:0] last_spawn = 3'b000;
   logic [2:0] busy_prev  = 3'b000;

`ifdef OBSTACLE_SCHED_BIRD_EN
   localparam int EXP_SPAWN3 = 4;
   localparam int EXP_SPAWN5 = 4;
`else
   localparam int EXP_SPAWN3 = 1;
   localparam int EXP_SPAWN5 = 1;
`endif

   always #5 clk_i = ~clk_i;

   obstacle_scheduler #(
      .MIN_GAP          (40),
      .SPAWNS_PER_LEVEL (8)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .next_frame_i (next_frame_i),
      .run_i        (run_i),
      .freeze_i     (freeze_i),
      .clear_i      (clear_i),
      .busy_i       (busy_i),
      .rand_i       (rand_i),
      .spawn_o      (spawn_o),
      .step_o       (step_o),
      .level_o      (level_o)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (step_o) n_step++;
      if (spawn_o != 3'b000) begin
         n_spawn++;
         last_spawn = spawn_o;
         chk("spawn_onehot", $countones(spawn_o), 1);
         chk("spawn_into_busy", int'(spawn_o & busy_prev), 0);
      end
      busy_prev = busy_i;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic frame();
      next_frame_i = 1'b1;
      tick();
      next_frame_i = 1'b0;
      repeat (3) tick();
   endtask

   task automatic wait_spawn(input int max_frames, output int frames, output int steps,
                             output int seen);
      int s0;
      int st0;
      s0 = n_spawn;
      st0 = n_step;
      frames = 0;
      while (n_spawn == s0 && frames < max_frames) begin
         frame();
         frames++;
      end
      steps = n_step - st0;
      seen = (n_spawn != s0) ? 1 : 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int fr, st, seen, st0, sp0, st24, exp_gap, stw, guard;

      rst_ni = 1'b0; next_frame_i = 1'b0; run_i = 1'b0; freeze_i = 1'b0;
      clear_i = 1'b0; busy_i = 3'b000; rand_i = 16'h0000;
      repeat (3) tick();
      chk("rst_spawn", int'(spawn_o), 0);
      chk("rst_step", int'(step_o), 0);
      chk("rst_level", int'(level_o), 0);
      rst_ni = 1'b1;
      tick();
      chk("rst_state", int'(dut.state_q), int'(IDLE));
      chk("rst_gap", int'(dut.gap_cnt_q), 0);
      frame();
      chk("idle_no_step", n_step, 0);

      // First spawn: 40 steps at 2 of 4 frames
      run_i = 1'b1;
      tick(); tick();
      chk("enter_wait", int'(dut.state_q), int'(WAIT));
      chk("gap_load", int'(dut.gap_cnt_q), 40);
      wait_spawn(200, fr, st, seen);
      chk("spawn1_seen", seen, 1);
      chk("spawn1_slot", int'(last_spawn), 1);
      chk("spawn1_steps", st, 40);
      chk("spawn1_within_80_frames", (fr <= 80) ? 1 : 0, 1);

      wait_spawn(200, fr, st, seen);
      chk("spawn2_seen", seen, 1);
      chk("spawn2_slot", int'(last_spawn), 2);
      chk("spawn2_steps", st, 40);
      wait_spawn(200, fr, st, seen);
      chk("spawn3_seen", seen, 1);
      chk("spawn3_slot", int'(last_spawn), EXP_SPAWN3);

      // All slots busy: sit in ARM with no pulse, then free slot 1 only
      busy_i = 3'b111;
      st0 = n_step; sp0 = n_spawn; guard = 0;
      while (n_step - st0 < 40 && guard < 200) begin
         frame();
         guard++;
      end
      chk("arm_reached", int'(dut.state_q), int'(ARM));
      repeat (100) tick();
      chk("arm_blocked", n_spawn - sp0, 0);
      busy_i = 3'b101;
      @(negedge clk_i);
      chk("arm_no_early_pulse", int'(spawn_o), 0);
      tick();
      @(negedge clk_i);
      chk("arm_unblock_slot1", int'(spawn_o), 2);
      tick();
      @(negedge clk_i);
      chk("arm_pulse_one_cycle", int'(spawn_o), 0);
      tick();
      busy_i = 3'b000;
      chk("level_after_4", int'(level_o), 0);

      for (int i = 5; i <= 24; i++) begin
         wait_spawn(200, fr, st, seen);
         chk("spawn_seen", seen, 1);
         if (i == 5) begin
            chk("spawn5_slot", int'(last_spawn), EXP_SPAWN5);
            chk("spawn5_steps", st, 40);
         end
         if (i == 7) chk("level_after_7", int'(level_o), 0);
         if (i == 8) begin
            chk("level_after_8", int'(level_o), 1);
            st0 = n_step;
            repeat (8) frame();
            chk("level1_steps_per_8_frames", n_step - st0, 6);
         end
         if (i == 15) chk("level_after_15", int'(level_o), 1);
         if (i == 16) begin
            chk("level_after_16", int'(level_o), 2);
            st0 = n_step;
            repeat (8) frame();
            chk("level2_steps_per_8_frames", n_step - st0, 8);
         end
         if (i == 19) rand_i = 16'hABC3;
         if (i == 20) rand_i = 16'h0000;
         if (i == 21) chk("rand_gap_steps", st, 43);
         if (i == 22) chk("gap_back_to_min", st, 40);
      end
      chk("level_after_24", int'(level_o), 2);
      st24 = n_step;
      st0 = n_step;
      repeat (4) frame();
      chk("level2_every_frame", n_step - st0, 4);

      // Freeze mid-WAIT
      exp_gap = 40 - (n_step - st24);
      freeze_i = 1'b1;
      tick();
      chk("frozen_state", int'(dut.state_q), int'(FROZEN));
      st0 = n_step; sp0 = n_spawn;
      repeat (10) frame();
      chk("freeze_no_step", n_step - st0, 0);
      chk("freeze_no_spawn", n_spawn - sp0, 0);
      chk("freeze_gap_held", int'(dut.gap_cnt_q), exp_gap);
      chk("freeze_level_held", int'(level_o), 2);
      clear_i = 1'b1;
      freeze_i = 1'b0;
      tick();
      clear_i = 1'b0;
      @(negedge clk_i);
      chk("clear_state", int'(dut.state_q), int'(IDLE));
      chk("clear_level", int'(level_o), 0);
      chk("clear_gap", int'(dut.gap_cnt_q), 0);
      tick();
      chk("rerun_wait", int'(dut.state_q), int'(WAIT));

      // clear_i beats a coincident frame pulse
      clear_i = 1'b1;
      next_frame_i = 1'b1;
      @(negedge clk_i);
      chk("clear_with_frame_step", int'(step_o), 0);
      tick();
      clear_i = 1'b0;
      next_frame_i = 1'b0;
      tick(); tick();
      stw = n_step;
      frame();
      chk("step_after_clear", n_step - stw, 1);

      // Reset while ARM holds a pick
      guard = 0;
      while (n_step - stw < 39 && guard < 200) begin
         frame();
         guard++;
      end
      sp0 = n_spawn;
      next_frame_i = 1'b1;
      tick();
      next_frame_i = 1'b0;
      tick();
      @(negedge clk_i);
      chk("arm_before_reset", int'(dut.state_q), int'(ARM));
      rst_ni = 1'b0;
      tick();
      @(negedge clk_i);
      chk("reset_drops_pick", int'(spawn_o), 0);
      chk("reset_state", int'(dut.state_q), int'(IDLE));
      rst_ni = 1'b1;
      tick();
      chk("reset_no_spawn_count", n_spawn - sp0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
